// File: rtl/tx_blk_dma_reader.sv
// tx_blk_dma_reader: read side of the TX link arbiter FIFO.
// Waits for a full 4KB block (128 x 256-bit beats), streams it to the TLP
// builder as PAYLOAD_BEATS-sized memory-write chunks addressed into a per-link
// host ring, then pops the link-number FIFO and reports block completion.
// Optional feature macro: TX_BLK_DMA_READER_UNDERRUN_CHK_EN
//   defined   -> VALID follows ~iFIFO_EMPTY in XFER, sticky underrun flag.
//   undefined -> VALID held high through XFER, oREG_UNDERRUN_ERR tied low.
module tx_blk_dma_reader #(
  parameter int unsigned PORTS          = 12,
  parameter int unsigned PORT_WIDTH     = $clog2(PORTS),
  parameter int unsigned PAYLOAD_BEATS  = 8,
  parameter int unsigned RING_BLKS_LOG2 = 4
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  // data FIFO (show-ahead)
  input  logic [255:0]                 iFIFO_DATA,
  input  logic                         iFIFO_EMPTY,
  input  logic [7:0]                   iFIFO_USED,
  input  logic [PORT_WIDTH-1:0]        iLINK_NUMBER,
  output logic                         oFIFO_RD_ACK,
  output logic                         oBLK_DONE_PULSE,
  // configuration
  input  logic                         iREG_ENABLE,
  input  logic [PORTS-1:0][63:0]       iREG_RING_BASE,
  // TLP builder stream
  output logic                         oTX_VALID,
  input  logic                         iTX_READY,
  output logic                         oTX_SOP,
  output logic                         oTX_EOP,
  output logic [255:0]                 oTX_DATA,
  output logic [63:0]                  oTX_ADDR,
  output logic [9:0]                   oTX_LEN,
  output logic [PORT_WIDTH-1:0]        oTX_LINK,
  // block completion towards the arbiter
  output logic                         oHIP_BLK_DONE,
  output logic [PORT_WIDTH-1:0]        oHIP_LINK_NUMBER,
  // debug / status
  output logic [1:0]                   oREG_PS,
  output logic                         oREG_UNDERRUN_ERR
);

  localparam int unsigned BLK_BEATS = 128;
  localparam int unsigned BEAT_W    = 7;
  localparam int unsigned PAGE_W    = 52;
  localparam int unsigned CHUNK_W   = $clog2(PAYLOAD_BEATS);
  localparam int unsigned LEN_DW    = PAYLOAD_BEATS * 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;

  logic [PORT_WIDTH-1:0]       r_link;
  logic [PAGE_W-1:0]           r_blk_base;
  logic [BEAT_W-1:0]           r_beat_ctr;
  logic [RING_BLKS_LOG2-1:0]   r_blk_idx [PORTS];
  logic                        r_hip_done;
  logic [PORT_WIDTH-1:0]       r_hip_link;

  logic                        w_start;
  logic                        w_in_xfer;
  logic                        w_valid;
  logic                        w_accept;
  logic                        w_last_beat;
  logic                        w_blk_done;
  logic [PAGE_W-1:0]           w_sel_page;
  logic [RING_BLKS_LOG2-1:0]   w_sel_idx;
  logic [PAGE_W-1:0]           w_hdr_page;
  logic [CHUNK_W-1:0]          w_chunk_pos;
  logic                        w_unused_ring_lo;

  // Start condition: enabled and a complete block resident in the data FIFO
  assign w_start     = iREG_ENABLE & ~iFIFO_EMPTY & (iFIFO_USED >= 8'(BLK_BEATS));
  assign w_in_xfer   = (r_state == S_XFER);
  assign w_last_beat = (r_beat_ctr == BEAT_W'(BLK_BEATS - 1));
  assign w_accept    = w_valid & iTX_READY;
  assign w_blk_done  = w_in_xfer & w_accept & w_last_beat;
  assign w_chunk_pos = r_beat_ctr[CHUNK_W-1:0];

  // Ring base low 12 bits are ignored (block-aligned)
  assign w_unused_ring_lo = ^iREG_RING_BASE;

  // FSM state register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state and stream valid
  always_comb begin
    w_next_state = r_state;
    w_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next_state = S_HDR;
        end
      end
      S_HDR: begin
        w_next_state = S_XFER;
      end
      S_XFER: begin
`ifdef TX_BLK_DMA_READER_UNDERRUN_CHK_EN
        w_valid = ~iFIFO_EMPTY;
`else
        w_valid = 1'b1;
`endif
        if (w_valid & iTX_READY & w_last_beat) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Select ring base page and ring index of the link at the FIFO head
  always_comb begin
    w_sel_page = '0;
    w_sel_idx  = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (iLINK_NUMBER == PORT_WIDTH'(i)) begin
        w_sel_page = iREG_RING_BASE[i][63:12];
        w_sel_idx  = r_blk_idx[i];
      end
    end
  end

  // Block page = ring page + ring index, wrapping modulo 2^52
  assign w_hdr_page = w_sel_page + PAGE_W'(w_sel_idx);

  // Block context: link, base page and beat counter
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_link     <= '0;
      r_blk_base <= '0;
      r_beat_ctr <= '0;
    end else if (r_state == S_HDR) begin
      r_link     <= iLINK_NUMBER;
      r_blk_base <= w_hdr_page;
      r_beat_ctr <= '0;
    end else if (w_in_xfer && w_accept) begin
      r_beat_ctr <= r_beat_ctr + BEAT_W'(1);
    end
  end

  // Per-link ring index, advanced once per completed block
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        r_blk_idx[i] <= '0;
      end
    end else if (r_state == S_DONE) begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        if (r_link == PORT_WIDTH'(i)) begin
          r_blk_idx[i] <= r_blk_idx[i] + RING_BLKS_LOG2'(1);
        end
      end
    end
  end

  // Block-done pulse to the arbiter, one cycle after the last beat is taken
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_hip_done <= 1'b0;
      r_hip_link <= '0;
    end else begin
      r_hip_done <= w_blk_done;
      r_hip_link <= w_blk_done ? r_link : '0;
    end
  end

`ifdef TX_BLK_DMA_READER_UNDERRUN_CHK_EN
  logic r_underrun;

  // Sticky underrun flag: data FIFO ran dry while streaming a block
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_underrun <= 1'b0;
    end else if (w_in_xfer && iFIFO_EMPTY) begin
      r_underrun <= 1'b1;
    end
  end

  assign oREG_UNDERRUN_ERR = r_underrun;
`else
  assign oREG_UNDERRUN_ERR = 1'b0;
`endif

  // Stream outputs; address is block page plus the byte offset of the beat
  assign oTX_VALID        = w_valid;
  assign oFIFO_RD_ACK     = w_accept;
  assign oBLK_DONE_PULSE  = w_blk_done;
  assign oTX_SOP          = w_in_xfer & (w_chunk_pos == '0);
  assign oTX_EOP          = w_in_xfer & (w_chunk_pos == CHUNK_W'(PAYLOAD_BEATS - 1));
  assign oTX_DATA         = iFIFO_DATA;
  assign oTX_ADDR         = w_in_xfer ? {r_blk_base, r_beat_ctr, 5'b0} : 64'd0;
  assign oTX_LEN          = 10'(LEN_DW);
  assign oTX_LINK         = r_link;
  assign oHIP_BLK_DONE    = r_hip_done;
  assign oHIP_LINK_NUMBER = r_hip_link;
  assign oREG_PS          = r_state;

endmodule

// File: doc/tx_blk_dma_reader.md
# tx_blk_dma_reader

Read-side consumer of the TX link arbiter FIFO. It waits until a complete 4KB block (128 × 256-bit beats) is resident, then streams it to the TLP builder as PAYLOAD_BEATS-sized memory-write chunks. Each chunk carries a per-link ring-buffer address. At block end it pops the link-number FIFO and returns a block-done indication, which drives the arbiter's per-link flush counters.

## Interface
- PORTS, 12: number of DPL links.
- PORT_WIDTH, $clog2(PORTS): link-number width.
- PAYLOAD_BEATS, 8: beats per chunk; legal values 4, 8, 16 (128/256/512 B).
- RING_BLKS_LOG2, 4: log2 of 4KB blocks per link host ring.
- iCLK  in  1  clock.
- iRST  in  1  reset, asynchronous, active-high.
- iFIFO_DATA  in  256  show-ahead data-FIFO head.
- iFIFO_EMPTY  in  1  data FIFO empty.
- iFIFO_USED  in  8  data FIFO occupancy.
- iLINK_NUMBER  in  PORT_WIDTH  link-number FIFO head (show-ahead).
- oFIFO_RD_ACK  out  1  data FIFO pop.
- oBLK_DONE_PULSE  out  1  link-number FIFO pop.
- iREG_ENABLE  in  1  permits starting new blocks.
- iREG_RING_BASE  in  [PORTS-1:0][63:0]  per-link ring base; bits [11:0] ignored.
- oTX_VALID  out  1  beat valid.
- iTX_READY  in  1  beat accepted when VALID & READY.
- oTX_SOP / oTX_EOP  out  1 / 1  chunk first / last beat.
- oTX_DATA  out  256  beat data.
- oTX_ADDR  out  64  chunk byte address; valid on SOP beat.
- oTX_LEN  out  10  chunk length in DW, constant PAYLOAD_BEATS*8.
- oTX_LINK  out  PORT_WIDTH  link of current block.
- oHIP_BLK_DONE  out  1  one-cycle block-complete pulse.
- oHIP_LINK_NUMBER  out  PORT_WIDTH  link for oHIP_BLK_DONE.
- oREG_PS  out  2  FSM state, for debug.
- oREG_UNDERRUN_ERR  out  1  sticky underrun flag (see Configuration).

## Operation
- FSM states: IDLE=0, HDR=1, XFER=2, DONE=3.
  - IDLE→HDR when iREG_ENABLE & ~iFIFO_EMPTY & iFIFO_USED≥128.
  - HDR→XFER unconditionally.
  - XFER→DONE on acceptance of beat 127.
  - DONE→IDLE unconditionally.
- HDR latches:
  - link_r ← iLINK_NUMBER.
  - blk_base_r ← {iREG_RING_BASE[link][63:12] + blk_idx[link], 12'h000}; the sum is 52-bit and wraps modulo 2^52.
  - beat_ctr (7-bit) ← 0.
- In XFER:
  - oTX_VALID=1, oTX_DATA=iFIFO_DATA (combinational pass-through), oFIFO_RD_ACK = oTX_VALID & iTX_READY.
  - beat_ctr increments on each accept.
  - oTX_SOP = (beat_ctr % PAYLOAD_BEATS == 0); oTX_EOP = (beat_ctr % PAYLOAD_BEATS == PAYLOAD_BEATS-1).
  - oTX_ADDR = blk_base_r | {beat_ctr, 5'b0}.
- oBLK_DONE_PULSE is asserted combinationally in the same cycle as the beat-127 acceptance.
- DONE:
  - oHIP_BLK_DONE=1 and oHIP_LINK_NUMBER=link_r, registered, for one cycle.
  - blk_idx[link_r] increments modulo 2^RING_BLKS_LOG2 (15→0 at default).
- Deasserting iREG_ENABLE mid-block does not abort the block; it only blocks the IDLE→HDR transition.
- iREG_RING_BASE is sampled only in HDR; changes mid-block take effect on the next block.
- Reset mid-operation: all state returns to reset values, including every blk_idx=0. The partial block is discarded; the upstream FIFOs are reset by the same iRST.

## Timing
- Reset values: every output is 0, except oTX_LEN (constant) and oTX_DATA (follows iFIFO_DATA, don't-care while VALID=0).
- Start latency: condition true in IDLE at cycle N → HDR at N+1 → first oTX_VALID at N+2.
- Full block with iTX_READY held high: 128 XFER cycles + 1 DONE cycle.
- Minimum block-to-block spacing is 131 cycles (IDLE, HDR, 128 XFER, DONE).
- Ready/valid handshake: VALID never drops mid-block. DATA, SOP, EOP and ADDR are held stable while VALID & ~READY.
- oHIP_BLK_DONE is asserted exactly 1 cycle after the cycle in which oBLK_DONE_PULSE is asserted.

## Configuration
- TX_BLK_DMA_READER_UNDERRUN_CHK_EN defined:
  - In XFER, oTX_VALID = ~iFIFO_EMPTY.
  - oREG_UNDERRUN_ERR sets (sticky until iRST) on any XFER cycle with iFIFO_EMPTY=1.
  - The block resumes when data returns.
- Undefined: no empty check; oTX_VALID=1 throughout XFER; oREG_UNDERRUN_ERR tied 0.

## Test plan
- Single block: link 5, base 0x1_2345_6000, blk_idx 0, READY=1, PAYLOAD_BEATS=8.
  - Expect 16 SOP/EOP pairs at addresses 0x1_2345_6000 + k·0x100, oTX_LEN=64.
  - Expect exactly 128 RD_ACKs, 1 oBLK_DONE_PULSE, and oHIP_BLK_DONE with link 5 one cycle later.
- Ring wrap: 17 back-to-back blocks on link 2 with base 0x8000_0000.
  - Block 16 starts at 0x8000_F000; block 17 starts at 0x8000_0000 again.
  - blk_idx of all other links remains 0.
- Backpressure: toggle iTX_READY randomly at 50% during a block.
  - DATA/ADDR/SOP stay stable while stalled; exactly 128 acks; data order matches FIFO order.
- Start gating:
  - iFIFO_USED=127 keeps the FSM in IDLE; 128 starts HDR on the next cycle.
  - iREG_ENABLE=0 holds IDLE; dropping iREG_ENABLE at beat 40 still completes all 128 beats.
- Reset at beat 60: all outputs return to 0 asynchronously and blk_idx clears; the next block on the same link starts at base+0.
- Underrun, with the macro defined: force iFIFO_EMPTY for 3 cycles at beat 20.
  - VALID drops for those 3 cycles and oREG_UNDERRUN_ERR=1.
  - The block still completes with 128 beats.
